// File: rtl/multi_channel_capture_buffer.sv
// multi_channel_capture_buffer
//   Captures NUM_CH ADC channels in lock-step into a shared ring buffer with a
//   pre-trigger window. After the trigger it records a fixed number of
//   post-trigger samples and freezes. Any channel's frame can then be
//   streamed out oldest-first over a valid/ready handshake.
//
// Ports
//   clk, reset_b           system clock, async active-low reset
//   sample_data/_valid     NUM_CH packed samples, one strobe for all channels
//   arm, trigger           capture control pulses
//   rd_ch_sel, rd_start    channel select (latched on rd_start), start readout
//   rd_ready               consumer ready
//   rd_data/_valid/_last   readout stream, rd_last on the DEPTH-th sample
//   capture_done           frame frozen (DONE or READ)
//   overrun                sticky, a sample arrived while frozen
//   state                  encoded FSM state for debug
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE  0 | waiting for arm, samples ignored
// FILL  1 | writing, collecting the pre-trigger window
// ARMED 2 | pre-trigger window full, ring keeps wrapping, waiting trigger
// POST  3 | collecting post-trigger samples
// DONE  4 | frame frozen, waiting for rd_start or arm
// READ  5 | streaming the selected channel's frame
module multi_channel_capture_buffer #(
    parameter  int NUM_CH   = 4,
    parameter  int SAMPLE_W = 10,
    parameter  int DEPTH    = 1024,
    parameter  int PRE_TRIG = 256,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic                       sample_valid,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic [CH_W-1:0]            rd_ch_sel,
    input  logic                       rd_start,
    input  logic                       rd_ready,
    output logic [SAMPLE_W-1:0]        rd_data,
    output logic                       rd_valid,
    output logic                       rd_last,
    output logic                       capture_done,
    output logic                       overrun,
    output logic [2:0]                 state
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] PRE_A    = ADDR_W'(PRE_TRIG);
    localparam logic [CNT_W-1:0]  POST_LEN = CNT_W'(DEPTH - PRE_TRIG);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CH_W:0]     NUM_CH_C = (CH_W + 1)'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4,
        S_READ  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr, pre_cnt, trig_addr, rd_addr;
    logic [CNT_W-1:0]  post_cnt, rd_issue_left, rd_xfer_left;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_valid_q, overrun_q;
    logic [SAMPLE_W-1:0] ram_q;
    logic [SAMPLE_W-1:0] mem [NUM_CH][DEPTH];

    logic pre_full, arm_restart, trig_ok, wr_en, post_hit;
    logic rd_accept, rd_issue, rd_xfer, rd_final, sample_dropped;

    // Trigger is honoured as soon as the pre-trigger window is full, including
    // the FILL cycle in which pre_cnt has just saturated. arm beats everything.
    assign pre_full       = (pre_cnt == PRE_A);
    assign arm_restart    = arm && (state_q != S_READ);
    assign trig_ok        = trigger && !arm &&
                            ((state_q == S_ARMED) || ((state_q == S_FILL) && pre_full));
    assign wr_en          = sample_valid && !arm &&
                            (state_q inside {S_FILL, S_ARMED, S_POST});
    assign post_hit       = ((post_cnt + CNT_W'(1)) == POST_LEN);
    assign rd_accept      = (state_q == S_DONE) && rd_start && !arm;
    // The RAM output register is the output stage: a new read is only issued
    // when the current word is empty or leaving, so a stall simply holds it.
    assign rd_issue       = (state_q == S_READ) && (rd_issue_left != '0) &&
                            (!rd_valid_q || rd_ready);
    assign rd_xfer        = (state_q == S_READ) && rd_valid_q && rd_ready;
    assign rd_final       = rd_xfer && (rd_xfer_left == CNT_W'(1));
    assign sample_dropped = sample_valid &&
                            (((state_q == S_DONE) && !arm) || (state_q == S_READ));

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm) state_d = S_FILL;
            S_FILL, S_ARMED: begin
                if (arm)
                    state_d = S_FILL;
                else if (trig_ok)
                    state_d = (sample_valid && (POST_LEN == CNT_W'(1))) ? S_DONE : S_POST;
                else if ((state_q == S_FILL) && pre_full)
                    state_d = S_ARMED;
            end
            S_POST: begin
                if (arm)                           state_d = S_FILL;
                else if (sample_valid && post_hit) state_d = S_DONE;
            end
            S_DONE: begin
                if (arm)           state_d = S_FILL;
                else if (rd_start) state_d = S_READ;
            end
            S_READ:  if (rd_final) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        capture_done = (state_q == S_DONE) || (state_q == S_READ);
        rd_valid     = rd_valid_q;
        rd_last      = rd_valid_q && (rd_xfer_left == CNT_W'(1));
        rd_data      = rd_valid_q ? ram_q : '0;
        overrun      = overrun_q;
        state        = state_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr        <= '0;
            pre_cnt       <= '0;
            post_cnt      <= '0;
            trig_addr     <= '0;
            overrun_q     <= 1'b0;
            rd_ch         <= '0;
            rd_addr       <= '0;
            rd_issue_left <= '0;
            rd_xfer_left  <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            if (arm_restart) begin
                wr_ptr    <= '0;
                pre_cnt   <= '0;
                post_cnt  <= '0;
                trig_addr <= '0;
                overrun_q <= 1'b0;
            end else begin
                if (wr_en)
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_en && (state_q == S_FILL) && !pre_full)
                    pre_cnt <= pre_cnt + ADDR_W'(1);
                // wr_ptr is both the address of a coincident sample and the
                // address of the next one, so trig_addr needs no special case.
                if (trig_ok) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= sample_valid ? CNT_W'(1) : '0;
                end else if ((state_q == S_POST) && sample_valid) begin
                    post_cnt <= post_cnt + CNT_W'(1);
                end
                if (sample_dropped)
                    overrun_q <= 1'b1;
            end

            if (rd_accept) begin
                rd_ch         <= ({1'b0, rd_ch_sel} < NUM_CH_C) ? rd_ch_sel : '0;
                rd_addr       <= trig_addr - PRE_A;
                rd_issue_left <= DEPTH_C;
                rd_xfer_left  <= DEPTH_C;
            end else begin
                if (rd_issue) begin
                    rd_addr       <= rd_addr + ADDR_W'(1);
                    rd_issue_left <= rd_issue_left - CNT_W'(1);
                end
                if (rd_xfer)
                    rd_xfer_left <= rd_xfer_left - CNT_W'(1);
            end

            if (rd_issue)
                rd_valid_q <= 1'b1;
            else if (rd_xfer || (state_q != S_READ))
                rd_valid_q <= 1'b0;
        end
    end

    // Sample storage, not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NUM_CH; k++)
                mem[k][wr_ptr] <= sample_data[k*SAMPLE_W +: SAMPLE_W];
        end
        if (rd_issue)
            ram_q <= mem[rd_ch][rd_addr];
    end

endmodule
